// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch sequencer.
// The block fetches one 16-bit word from instruction memory at the current pc.
// It then issues the word to the control unit and waits for done before
// fetching the next word. A HALT word (16'hE000) parks the block until reset.
// All outputs come straight from registers.
module instr_fetch #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              run,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  input  logic              mem_valid,
  output logic [15:0]       instr,
  output logic              new_instr,
  input  logic              done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_d,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  // Encoded sequencer states. S_ISSUE lasts exactly one cycle.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [15:0] HALT_WORD = 16'hE000;

  // HALT is the single word with opcode 3'b111 and every other bit clear.
  function automatic logic is_halt(input logic [15:0] word);
    return (word == HALT_WORD);
  endfunction

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;
  logic              r_mem_rd;
  logic              r_new_instr;
  logic              r_halted;
  logic [ADDR_W-1:0] w_pc_inc;

  // The increment is modulo 2^ADDR_W, so the all-ones pc wraps to zero.
  assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Sequencer. Every output is registered, so each output is set on the
  // transition into the state where that output must be visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pc        <= {ADDR_W{1'b0}};
      r_instr     <= 16'h0000;
      r_mem_rd    <= 1'b0;
      r_new_instr <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      // new_instr is a one-cycle pulse. It is raised only on a fetch capture.
      r_new_instr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_halted <= 1'b0;
          if (run) begin
            r_state  <= S_FETCH;
            r_mem_rd <= 1'b1;
          end else begin
            r_state  <= S_IDLE;
            r_mem_rd <= 1'b0;
          end
        end

        S_FETCH: begin
          r_halted <= 1'b0;
          // run and pc_load are not looked at here. A started fetch always completes.
          if (mem_valid) begin
            r_instr     <= mem_data;
            r_pc        <= w_pc_inc;
            r_mem_rd    <= 1'b0;
            // Decide on the pulse now so that new_instr is high in the
            // S_ISSUE cycle, one cycle after mem_valid.
            r_new_instr <= !is_halt(mem_data);
            r_state     <= S_ISSUE;
          end else begin
            r_mem_rd <= 1'b1;
            r_state  <= S_FETCH;
          end
        end

        S_ISSUE: begin
          r_mem_rd <= 1'b0;
          if (is_halt(r_instr)) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state  <= S_EXEC;
            r_halted <= 1'b0;
          end
        end

        S_EXEC: begin
          r_halted <= 1'b0;
          // A jump taken together with done makes the next fetch use pc_d.
          if (pc_load) begin
            r_pc <= pc_d;
          end else begin
            r_pc <= r_pc;
          end
          if (done) begin
            if (run) begin
              r_state  <= S_FETCH;
              r_mem_rd <= 1'b1;
            end else begin
              r_state  <= S_IDLE;
              r_mem_rd <= 1'b0;
            end
          end else begin
            r_state  <= S_EXEC;
            r_mem_rd <= 1'b0;
          end
        end

        S_HALT: begin
          // Only reset leaves this state. run, done and pc_load are ignored.
          r_state  <= S_HALT;
          r_mem_rd <= 1'b0;
          r_halted <= 1'b1;
        end

        default: begin
          // An illegal encoding falls back to a quiet idle.
          r_state  <= S_IDLE;
          r_mem_rd <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign new_instr = r_new_instr;
  assign halted    = r_halted;

endmodule
